// File: rtl/calc_seq_pkg.sv
// calc_seq shared definitions
// State encoding, message codes and request word layout
package calc_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_CMP       = 4'd1,
    S_WAIT_CMP  = 4'd2,
    S_ALU       = 4'd3,
    S_WAIT_ALU  = 4'd4,
    S_CONV      = 4'd5,
    S_WAIT_CONV = 4'd6,
    S_DISP      = 4'd7,
    S_DONE      = 4'd8,
    S_ERR       = 4'd9
  } state_t;

  localparam logic [1:0] MSG_NORMAL = 2'b00;
  localparam logic [1:0] MSG_ERR    = 2'b11;

  localparam int A_LSB  = 0;
  localparam int B_LSB  = 8;
  localparam int OP_LSB = 16;

endpackage

// File: rtl/calc_seq.sv
// calc_seq: sequences cmp, alu, conv and display stages
// with per-stage done handshakes and a wait timeout
module calc_seq
  import calc_seq_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int WORD_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  output logic [WORD_W-1:0] word_out,
  output logic              cmp_sel,
  input  logic              cmp_done,
  output logic              alu_sel,
  input  logic              alu_done,
  output logic              conv_sel,
  input  logic              conv_done,
  output logic              disp_sel,
  output logic              wr_en,
  output logic [1:0]        msg,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CLG = $clog2(TIMEOUT + 1);
  localparam int CW  = (CLG > 8) ? CLG : 8;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          wait_done;

  // Done level of the stage currently being waited on
  always_comb begin
    wait_done = 1'b0;
    unique case (state_q)
      S_WAIT_CMP:  wait_done = cmp_done;
      S_WAIT_ALU:  wait_done = alu_done;
      S_WAIT_CONV: wait_done = conv_done;
      default:     wait_done = 1'b0;
    endcase
  end

  // Sequencer FSM with registered strobes and status
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      word_out <= '0;
      cmp_sel  <= 1'b0;
      alu_sel  <= 1'b0;
      conv_sel <= 1'b0;
      disp_sel <= 1'b0;
      wr_en    <= 1'b0;
      msg      <= MSG_NORMAL;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      cmp_sel  <= 1'b0;
      alu_sel  <= 1'b0;
      conv_sel <= 1'b0;
      disp_sel <= 1'b0;
      wr_en    <= 1'b0;
      done     <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q  <= S_CMP;
            word_out <= word_in;
            err      <= 1'b0;
            msg      <= MSG_NORMAL;
            busy     <= 1'b1;
            cmp_sel  <= 1'b1;
            wr_en    <= 1'b1;
          end else if (state_q == S_DONE) begin
            state_q <= S_IDLE;
          end
        end
        S_CMP: begin
          state_q <= S_WAIT_CMP;
          cnt_q   <= '0;
        end
        S_ALU: begin
          state_q <= S_WAIT_ALU;
          cnt_q   <= '0;
        end
        S_CONV: begin
          state_q <= S_WAIT_CONV;
          cnt_q   <= '0;
        end
        S_WAIT_CMP, S_WAIT_ALU, S_WAIT_CONV: begin
          if (wait_done) begin
            wr_en <= 1'b1;
            if (state_q == S_WAIT_CMP) begin
              state_q <= S_ALU;
              alu_sel <= 1'b1;
            end else if (state_q == S_WAIT_ALU) begin
              state_q  <= S_CONV;
              conv_sel <= 1'b1;
            end else begin
              state_q  <= S_DISP;
              disp_sel <= 1'b1;
            end
          end else if (cnt_q == LAST) begin
            state_q  <= S_ERR;
            err      <= 1'b1;
            msg      <= MSG_ERR;
            busy     <= 1'b0;
            disp_sel <= 1'b1;
            wr_en    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DISP: begin
          state_q <= S_DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_seq.sv
// tb_calc_seq: scoreboard bench for calc_seq
// Expected event timeline computed per run from stage delays
module tb_calc_seq;

  localparam int TO = 40;
  localparam int W  = 20;

  typedef struct {
    int         kind;
    int         cyc;
    logic [W-1:0] word;
  } ev_t;

  ev_t sb[$];

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] word_in;
  logic [W-1:0] word_out;
  logic         cmp_sel;
  logic         alu_sel;
  logic         conv_sel;
  logic         disp_sel;
  logic         wr_en;
  logic [1:0]   msg;
  logic         busy;
  logic         done;
  logic         err;
  logic [2:0]   dn = 3'b000;

  int dly[3];
  int cnt_r[3];
  bit tie = 1'b0;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic err_p = 1'b0;
  string names[6] = '{"cmp", "alu", "conv", "disp", "done", "err"};

  calc_seq #(.TIMEOUT(TO), .WORD_W(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .word_in(word_in), .word_out(word_out),
    .cmp_sel(cmp_sel), .cmp_done(dn[0]),
    .alu_sel(alu_sel), .alu_done(dn[1]),
    .conv_sel(conv_sel), .conv_done(dn[2]),
    .disp_sel(disp_sel), .wr_en(wr_en),
    .msg(msg), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
    $fatal(1);
  end

  // stage responders: done rises dly cycles after strobe, 0 = never
  always @(negedge clk) begin
    logic [2:0] s;
    s = {conv_sel, alu_sel, cmp_sel};
    for (int i = 0; i < 3; i++) begin
      if (tie) dn[i] = 1'b1;
      else if (s[i]) begin
        dn[i] = 1'b0;
        cnt_r[i] = dly[i];
      end else if (cnt_r[i] > 0) begin
        cnt_r[i]--;
        if (cnt_r[i] == 0) dn[i] = 1'b1;
      end
    end
  end

  task automatic check_ev(input int k);
    ev_t e;
    bit ok;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL event_%s cyc=%0d got unexpected event want none",
               names[k], cyc);
      return;
    end
    e = sb.pop_front();
    ok = (e.kind == k) && (e.cyc == cyc) && (word_out === e.word);
    if (k == 0) ok = ok && busy === 1'b1 && err === 1'b0 && msg === 2'b00;
    if (k == 4) ok = ok && busy === 1'b0 && err === 1'b0 && msg === 2'b00;
    if (k == 5) ok = ok && busy === 1'b0 && msg === 2'b11;
    if (!ok) begin
      n_bad++;
      $display("FAIL event_%s got cyc=%0d word=%h busy=%b err=%b msg=%b want %s cyc=%0d word=%h",
               names[k], cyc, word_out, busy, err, msg,
               names[e.kind], e.cyc, e.word);
    end
  endtask

  // monitor: strobe hygiene every cycle, events against scoreboard
  always @(negedge clk) begin
    logic [3:0] s;
    logic [5:0] ev;
    s = {disp_sel, conv_sel, alu_sel, cmp_sel};
    n_cmp++;
    if ($countones(s) > 1) begin
      n_bad++;
      $display("FAIL sel_onehot cyc=%0d got %b want at most one", cyc, s);
    end
    n_cmp++;
    if (wr_en !== (|s)) begin
      n_bad++;
      $display("FAIL wr_en cyc=%0d got %b want %b", cyc, wr_en, |s);
    end
    ev = {err & ~err_p, done, s};
    for (int i = 0; i < 6; i++)
      if (ev[i]) check_ev(i);
    err_p = err;
  end

  task automatic check_zero(input string nm);
    logic [W+9:0] v;
    v = {word_out, cmp_sel, alu_sel, conv_sel, disp_sel, wr_en,
         msg, busy, done, err};
    n_cmp++;
    if (v !== '0) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got outputs=%h want 0", nm, cyc, v);
    end
  endtask

  task automatic drain();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain cyc=%0d got %0d pending events want 0",
               cyc, sb.size());
    end
    sb.delete();
  endtask

  // one calculation; called at negedge+1, returns at negedge+1
  task automatic run(input logic [W-1:0] w, input int k0, input int k1,
                     input int k2, input bit inj, input bit rmid);
    int k[3];
    int t, tend, p;
    bit stop;
    k = '{k0, k1, k2};
    for (int i = 0; i < 3; i++) dly[i] = k[i];
    word_in = w;
    start = 1'b1;
    p = cyc + 1;
    sb.push_back('{0, p, w});
    t = p;
    tend = 0;
    stop = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (k[s] == 0) begin
        tend = t + 1 + TO;
        sb.push_back('{3, tend, w});
        sb.push_back('{5, tend, w});
        stop = 1'b1;
        break;
      end
      t += 1 + k[s];
      sb.push_back('{s + 1, t, w});
      if (rmid && s == 1) begin
        tend = t + 1;
        stop = 1'b1;
        break;
      end
    end
    if (!stop) begin
      tend = t + 1;
      sb.push_back('{4, tend, w});
    end
    @(negedge clk); #1;
    start = 1'b0;
    word_in = W'($urandom);
    if (inj) begin
      @(negedge clk); #1;
      start = 1'b1;
      word_in = 20'h2FFFF;
      @(negedge clk); #1;
      start = 1'b0;
    end
    while (cyc < tend) @(negedge clk);
    #1;
    drain();
    if (rmid) begin
      rst = 1'b1;
      start = 1'b1;
      word_in = 20'h2FFFF;
      @(negedge clk); #1;
      check_zero("reset_mid");
      rst = 1'b0;
      start = 1'b0;
    end
  endtask

  initial begin
    int g, h;
    int kk[3];
    rst = 1'b1;
    start = 1'b0;
    word_in = '0;
    for (int i = 0; i < 3; i++) begin
      dly[i] = 1;
      cnt_r[i] = 0;
    end
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk); #1;

    run(20'h10503, 2, 2, 2, 1'b0, 1'b0);
    run(20'h10503, 1, 1, 1, 1'b1, 1'b0);
    tie = 1'b1;
    run(W'($urandom), 1, 1, 1, 1'b0, 1'b0);
    tie = 1'b0;
    run(20'h10503, 1, 0, 1, 1'b0, 1'b0);
    run(W'($urandom), 2, 1, 3, 1'b0, 1'b0);
    run(20'h10503, 1, 1, 3, 1'b0, 1'b1);
    run(W'($urandom), 1, 2, 1, 1'b0, 1'b0);

    for (int r = 0; r < 30; r++) begin
      g = $urandom_range(0, 2);
      repeat (g) begin
        @(negedge clk); #1;
      end
      for (int i = 0; i < 3; i++) kk[i] = $urandom_range(1, 4);
      if ($urandom_range(0, 5) == 0) begin
        h = $urandom_range(0, 2);
        kk[h] = 0;
      end
      run(W'($urandom), kk[0], kk[1], kk[2],
          ($urandom_range(0, 3) == 0), 1'b0);
    end

    repeat (3) @(negedge clk);
    #1;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
